// File: rtl/regfile_sequencer.sv
// Command sequencer for a 16x8 register file: reads operands, runs a small ALU,
// writes the result back and reports the result with zero/carry flags.
module regfile_sequencer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs1,
    input  logic [ADDR_W-1:0] cmd_rs2,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              RegFileRead,
    output logic [ADDR_W-1:0] Source1,
    output logic [ADDR_W-1:0] Source2,
    input  logic [DATA_W-1:0] Dataout1,
    input  logic [DATA_W-1:0] Dataout2,
    output logic              RegFileWrite,
    output logic [ADDR_W-1:0] Destin,
    output logic [DATA_W-1:0] Datain,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              flag_z,
    output logic              flag_c
);

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_MOVI = 3'd5;
    localparam logic [2:0] OP_MOV  = 3'd6;
    localparam logic [2:0] OP_CMP  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e              state_q;
    logic [2:0]          op_q;
    logic [ADDR_W-1:0]   rd_q;
    logic [DATA_W-1:0]   imm_q;
    logic                cmd_ready_q;
    logic                rf_read_q;
    logic [ADDR_W-1:0]   src1_q;
    logic [ADDR_W-1:0]   src2_q;
    logic                rf_write_q;
    logic [ADDR_W-1:0]   destin_q;
    logic [DATA_W-1:0]   datain_q;
    logic                done_q;
    logic [DATA_W-1:0]   result_q;
    logic                flag_z_q;
    logic                flag_c_q;

    logic [DATA_W:0]     a_ext;
    logic [DATA_W:0]     b_ext;
    logic [DATA_W:0]     alu_d;
    logic [DATA_W-1:0]   result_d;
    logic                flag_z_d;
    logic                flag_c_d;

    // 9-bit ALU on live read data; bit DATA_W is carry (ADD) or borrow (SUB/CMP)
    always_comb begin
        a_ext    = {1'b0, Dataout1};
        b_ext    = {1'b0, Dataout2};
        alu_d    = '0;
        flag_c_d = 1'b0;
        unique case (op_q)
            OP_ADD: begin
                alu_d    = a_ext + b_ext;
                flag_c_d = alu_d[DATA_W];
            end
            OP_SUB, OP_CMP: begin
                alu_d    = a_ext - b_ext;
                flag_c_d = alu_d[DATA_W];
            end
            OP_AND:  alu_d = a_ext & b_ext;
            OP_OR:   alu_d = a_ext | b_ext;
            OP_XOR:  alu_d = a_ext ^ b_ext;
            OP_MOVI: alu_d = {1'b0, imm_q};
            OP_MOV:  alu_d = a_ext;
            default: alu_d = '0;
        endcase
        result_d = alu_d[DATA_W-1:0];
        flag_z_d = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_ADD;
            rd_q        <= '0;
            imm_q       <= '0;
            cmd_ready_q <= 1'b1;
            rf_read_q   <= 1'b0;
            src1_q      <= '0;
            src2_q      <= '0;
            rf_write_q  <= 1'b0;
            destin_q    <= '0;
            datain_q    <= '0;
            done_q      <= 1'b0;
            result_q    <= '0;
            flag_z_q    <= 1'b0;
            flag_c_q    <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            rf_write_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        op_q        <= cmd_op;
                        rd_q        <= cmd_rd;
                        imm_q       <= cmd_imm;
                        src1_q      <= cmd_rs1;
                        src2_q      <= cmd_rs2;
                        cmd_ready_q <= 1'b0;
                        if (cmd_op == OP_MOVI) begin
                            state_q <= S_EXEC;
                        end else begin
                            state_q   <= S_READ;
                            rf_read_q <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    result_q  <= result_d;
                    datain_q  <= result_d;
                    flag_z_q  <= flag_z_d;
                    flag_c_q  <= flag_c_d;
                    rf_read_q <= 1'b0;
                    if (op_q == OP_CMP) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= S_WRITE;
                        rf_write_q <= 1'b1;
                        destin_q   <= rd_q;
                    end
                end
                S_WRITE: begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                    rf_read_q   <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign RegFileRead  = rf_read_q;
    assign Source1      = src1_q;
    assign Source2      = src2_q;
    assign RegFileWrite = rf_write_q;
    assign Destin       = destin_q;
    assign Datain       = datain_q;
    assign done         = done_q;
    assign result       = result_q;
    assign flag_z       = flag_z_q;
    assign flag_c       = flag_c_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural 16x8 register file.
module tb_regfile_sequencer;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_MOVI = 3'd5;
    localparam logic [2:0] OP_MOV  = 3'd6;
    localparam logic [2:0] OP_CMP  = 3'd7;

    logic       clk = 1'b0;
    logic       Reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_rd;
    logic [3:0] cmd_rs1;
    logic [3:0] cmd_rs2;
    logic [7:0] cmd_imm;
    logic       RegFileRead;
    logic [3:0] Source1;
    logic [3:0] Source2;
    logic [7:0] Dataout1;
    logic [7:0] Dataout2;
    logic       RegFileWrite;
    logic [3:0] Destin;
    logic [7:0] Datain;
    logic       done;
    logic [7:0] result;
    logic       flag_z;
    logic       flag_c;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rf [16];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (RegFileWrite) rf[Destin] <= Datain;
    end
    assign Dataout1 = rf[Source1];
    assign Dataout2 = rf[Source2];

    regfile_sequencer #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk          (clk),
        .Reset        (Reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_rd       (cmd_rd),
        .cmd_rs1      (cmd_rs1),
        .cmd_rs2      (cmd_rs2),
        .cmd_imm      (cmd_imm),
        .RegFileRead  (RegFileRead),
        .Source1      (Source1),
        .Source2      (Source2),
        .Dataout1     (Dataout1),
        .Dataout2     (Dataout2),
        .RegFileWrite (RegFileWrite),
        .Destin       (Destin),
        .Datain       (Datain),
        .done         (done),
        .result       (result),
        .flag_z       (flag_z),
        .flag_c       (flag_c)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One command: per-cycle checks of handshake, read/write strobes and done,
    // then result/flags once back in IDLE.
    task automatic run_cmd(input string name, input logic [2:0] op, input logic [3:0] rd,
                           input logic [3:0] rs1, input logic [3:0] rs2, input logic [7:0] imm,
                           input logic [7:0] exp_res, input logic exp_z, input logic exp_c,
                           input bit hold);
        int  lat;
        bit  has_wr;
        bit  has_rd;
        lat    = (op == OP_MOVI || op == OP_CMP) ? 3 : 4;
        has_wr = (op != OP_CMP);
        has_rd = (op != OP_MOVI);
        cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        cmd_valid = 1'b1;
        check({name, " ready_before_accept"}, 8'(cmd_ready), 8'd1);
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
        cmd_op = ~op; cmd_rd = ~rd; cmd_rs1 = ~rs1; cmd_rs2 = ~rs2; cmd_imm = ~imm;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            check($sformatf("%s c%0d cmd_ready", name, k), 8'(cmd_ready), 8'd0);
            check($sformatf("%s c%0d done", name, k), 8'(done), 8'(k == lat));
            check($sformatf("%s c%0d RegFileRead", name, k), 8'(RegFileRead),
                  8'(has_rd && (k == 1 || k == 2)));
            check($sformatf("%s c%0d RegFileWrite", name, k), 8'(RegFileWrite),
                  8'(has_wr && k == lat - 1));
            if (has_rd && (k == 1 || k == 2)) begin
                check($sformatf("%s c%0d Source1", name, k), 8'(Source1), 8'(rs1));
                check($sformatf("%s c%0d Source2", name, k), 8'(Source2), 8'(rs2));
            end
            if (has_wr && k == lat - 1) begin
                check($sformatf("%s c%0d Destin", name, k), 8'(Destin), 8'(rd));
                check($sformatf("%s c%0d Datain", name, k), Datain, exp_res);
            end
            if (hold && k == lat) cmd_valid = 1'b0;
        end
        @(negedge clk);
        check({name, " ready_after"}, 8'(cmd_ready), 8'd1);
        check({name, " done_after"}, 8'(done), 8'd0);
        check({name, " result"}, result, exp_res);
        check({name, " flag_z"}, 8'(flag_z), 8'(exp_z));
        check({name, " flag_c"}, 8'(flag_c), 8'(exp_c));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0;
        cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst cmd_ready", 8'(cmd_ready), 8'd1);
        check("rst RegFileRead", 8'(RegFileRead), 8'd0);
        check("rst RegFileWrite", 8'(RegFileWrite), 8'd0);
        check("rst done", 8'(done), 8'd0);
        check("rst result", result, 8'h00);
        check("rst flag_z", 8'(flag_z), 8'd0);
        check("rst flag_c", 8'(flag_c), 8'd0);
        Reset = 1'b0;
        @(negedge clk);

        run_cmd("movi_r3",  OP_MOVI, 4'd3,  4'd0,  4'd0,  8'hAA, 8'hAA, 1'b0, 1'b0, 1'b0);
        run_cmd("movi_r7",  OP_MOVI, 4'd7,  4'd0,  4'd0,  8'h55, 8'h55, 1'b0, 1'b0, 1'b0);
        run_cmd("add_r1",   OP_ADD,  4'd1,  4'd3,  4'd7,  8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
        run_cmd("movi_r2",  OP_MOVI, 4'd2,  4'd0,  4'd0,  8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
        run_cmd("add_wrap", OP_ADD,  4'd4,  4'd2,  4'd1,  8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        run_cmd("cmp_hold", OP_CMP,  4'd0,  4'd7,  4'd3,  8'h00, 8'hAB, 1'b0, 1'b1, 1'b1);
        run_cmd("sub_r8",   OP_SUB,  4'd8,  4'd3,  4'd7,  8'h00, 8'h55, 1'b0, 1'b0, 1'b0);
        run_cmd("and_r6",   OP_AND,  4'd6,  4'd3,  4'd7,  8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        run_cmd("or_r10",   OP_OR,   4'd10, 4'd2,  4'd7,  8'h00, 8'h55, 1'b0, 1'b0, 1'b0);
        run_cmd("xor_r5",   OP_XOR,  4'd5,  4'd3,  4'd7,  8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
        run_cmd("mov_r9",   OP_MOV,  4'd9,  4'd3,  4'd0,  8'h00, 8'hAA, 1'b0, 1'b0, 1'b0);
        run_cmd("sub_brw",  OP_SUB,  4'd11, 4'd2,  4'd1,  8'h00, 8'h02, 1'b0, 1'b1, 1'b0);
        run_cmd("add_self", OP_ADD,  4'd3,  4'd3,  4'd3,  8'h00, 8'h54, 1'b0, 1'b1, 1'b0);
        run_cmd("mov_raw",  OP_MOV,  4'd12, 4'd3,  4'd0,  8'h00, 8'h54, 1'b0, 1'b0, 1'b0);
        run_cmd("sub_r13",  OP_SUB,  4'd13, 4'd12, 4'd7,  8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);
        check("rf r1", rf[1], 8'hFF);
        check("rf r4", rf[4], 8'h00);
        check("rf r0 untouched by cmp", rf[0] === 8'hAB ? 8'h01 : 8'h00, 8'h00);

        // Abort an ADD with reset while it is in READ
        cmd_op = OP_ADD; cmd_rd = 4'd14; cmd_rs1 = 4'd1; cmd_rs2 = 4'd2; cmd_imm = '0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("abort read_active", 8'(RegFileRead), 8'd1);
        Reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Reset = 1'b0;
        check("abort cmd_ready", 8'(cmd_ready), 8'd1);
        check("abort RegFileRead", 8'(RegFileRead), 8'd0);
        check("abort result", result, 8'h00);
        check("abort flag_z", 8'(flag_z), 8'd0);
        check("abort flag_c", 8'(flag_c), 8'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("abort c%0d done", k), 8'(done), 8'd0);
            check($sformatf("abort c%0d RegFileWrite", k), 8'(RegFileWrite), 8'd0);
            check($sformatf("abort c%0d cmd_ready", k), 8'(cmd_ready), 8'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
